// File: rtl/tel_arb_pkg.sv
// Shared types and constants for the tel line arbiter.
// State encoding, printable range, bill width, saturating add.
package tel_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RINGING,
    S_CALL,
    S_END,
    S_COOLDOWN
  } state_t;

  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;
  localparam int         BILL_W    = 32;

  function automatic logic is_print(
    input logic [7:0] c
  );
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

  function automatic logic [BILL_W-1:0] sat_add(
    input logic [BILL_W-1:0] a,
    input logic [BILL_W-1:0] b
  );
    logic [BILL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[BILL_W] ? '1 : s[BILL_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit from ptr up, with wrap.
// Ports: req/ptr in; one-hot gnt, its index idx, and any-request out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      pos = sum[IW-1:0];
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/tel_line_arbiter.sv
// Shares one tel call engine among N_USERS subscribers: grants, call pulses,
// char forwarding (valid/ready), per-user billing read via bill_sel/bill_out.
module tel_line_arbiter
  import tel_arb_pkg::*;
#(
  parameter int N_USERS       = 4,
  parameter int RING_TIMEOUT  = 16,
  parameter int COST_PER_CHAR = 2,
  parameter int COOLDOWN      = 8,
  localparam int IW           = $clog2(N_USERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_USERS-1:0]     call_req,
  input  logic [N_USERS-1:0]     hangup,
  input  logic                   callee_answer,
  input  logic                   callee_end,
  input  logic [N_USERS-1:0]     char_valid,
  input  logic [8*N_USERS-1:0]   char_data,
  output logic [N_USERS-1:0]     char_ready,
  output logic [N_USERS-1:0]     grant,
  output logic                   busy,
  output logic                   tel_startCall,
  output logic                   tel_answerCall,
  output logic                   tel_endCall,
  output logic                   tel_sendChar,
  output logic [7:0]             tel_charSent,
  input  logic [IW-1:0]          bill_sel,
  output logic [BILL_W-1:0]      bill_out
);

  state_t state, state_n;

  logic [N_USERS-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [IW-1:0]      gidx;
  logic [IW-1:0]      rr_ptr;

  logic [15:0] ring_cnt, ring_n;
  logic [15:0] cool_cnt, cool_n;

  logic        acc_q;
  logic        hup;
  logic        stop;
  logic        accept;
  logic        fwd;
  logic [7:0]  cur_char;
  logic [7:0]  chars [N_USERS];

  logic [BILL_W-1:0] bill [N_USERS];

  rr_arbiter #(
    .N  (N_USERS),
    .IW (IW)
  ) u_arb (
    .req (call_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  for (genvar i = 0; i < N_USERS; i++) begin : g_chars
    assign chars[i] = char_data[8*i +: 8];
  end

  // Only the owner's hangup/request matter; others are ignored while busy.
  assign hup      = hangup[gidx] | callee_end;
  assign stop     = hup | ~call_req[gidx];
  assign busy     = (state != S_IDLE);
  assign cur_char = chars[gidx];

  // acc_q blocks the cycle after any accept: at most one char per 2 cycles.
  assign char_ready =
    (state == S_CALL && !acc_q && !hup) ? grant : '0;
  assign accept = |(char_ready & char_valid);
  assign fwd    = accept && is_print(cur_char);

  assign bill_out =
    (32'(bill_sel) < N_USERS) ? bill[bill_sel] : '0;

  always_comb begin
    state_n = state;
    ring_n  = ring_cnt;
    cool_n  = cool_cnt;
    unique case (state)
      S_IDLE: begin
        if (arb_any) state_n = S_START;
      end
      S_START: begin
        state_n = S_RINGING;
        ring_n  = '0;
      end
      S_RINGING: begin
        if (callee_answer) begin
          state_n = S_CALL;
        end else if (stop) begin
          state_n = S_END;
        end else if (ring_cnt == 16'(RING_TIMEOUT-1)) begin
          state_n = S_END;
        end else begin
          ring_n = ring_cnt + 16'd1;
        end
      end
      S_CALL: begin
        if (stop) state_n = S_END;
      end
      S_END: begin
        state_n = S_COOLDOWN;
        cool_n  = '0;
      end
      S_COOLDOWN: begin
        if (cool_cnt == 16'(COOLDOWN-1)) begin
          state_n = S_IDLE;
        end else begin
          cool_n = cool_cnt + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      ring_cnt       <= '0;
      cool_cnt       <= '0;
      grant          <= '0;
      gidx           <= '0;
      rr_ptr         <= '0;
      acc_q          <= 1'b0;
      tel_startCall  <= 1'b0;
      tel_answerCall <= 1'b0;
      tel_endCall    <= 1'b0;
      tel_sendChar   <= 1'b0;
      tel_charSent   <= '0;
      for (int i = 0; i < N_USERS; i++) begin
        bill[i] <= '0;
      end
    end else begin
      state    <= state_n;
      ring_cnt <= ring_n;
      cool_cnt <= cool_n;
      acc_q    <= accept;

      // Pulses line up with entry into the state that causes them.
      tel_startCall  <= (state == S_IDLE)
                     && (state_n == S_START);
      tel_answerCall <= (state == S_RINGING)
                     && (state_n == S_CALL);
      tel_endCall    <= (state != S_END)
                     && (state_n == S_END);
      tel_sendChar   <= fwd;
      tel_charSent   <= fwd ? cur_char : '0;

      if (fwd) begin
        bill[gidx] <= sat_add(bill[gidx],
                              BILL_W'(COST_PER_CHAR));
      end

      if (state == S_IDLE && arb_any) begin
        grant <= arb_gnt;
        gidx  <= arb_idx;
      end

      if (state == S_COOLDOWN && state_n == S_IDLE) begin
        grant  <= '0;
        rr_ptr <= (gidx == IW'(N_USERS-1))
                ? '0 : gidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tel_line_arbiter.sv
// Scoreboard bench for tel_line_arbiter.
// Forwarded chars checked against a queue; pulses counted; bills modelled.
module tb_tel_line_arbiter;

  localparam int N   = 4;
  localparam int RT  = 16;
  localparam int CPC = 2;
  localparam int CD  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   call_req   = '0;
  logic [N-1:0]   hangup     = '0;
  logic           callee_answer = 1'b0;
  logic           callee_end    = 1'b0;
  logic [N-1:0]   char_valid = '0;
  logic [8*N-1:0] char_data  = '0;
  logic [N-1:0]   char_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           tel_startCall;
  logic           tel_answerCall;
  logic           tel_endCall;
  logic           tel_sendChar;
  logic [7:0]     tel_charSent;
  logic [1:0]     bill_sel = '0;
  logic [31:0]    bill_out;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_ans   = 0;
  int n_end   = 0;
  int n_send  = 0;
  int exp_bill [N];
  logic [7:0] exp_q [$];

  tel_line_arbiter #(
    .N_USERS       (N),
    .RING_TIMEOUT  (RT),
    .COST_PER_CHAR (CPC),
    .COOLDOWN      (CD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .call_req       (call_req),
    .hangup         (hangup),
    .callee_answer  (callee_answer),
    .callee_end     (callee_end),
    .char_valid     (char_valid),
    .char_data      (char_data),
    .char_ready     (char_ready),
    .grant          (grant),
    .busy           (busy),
    .tel_startCall  (tel_startCall),
    .tel_answerCall (tel_answerCall),
    .tel_endCall    (tel_endCall),
    .tel_sendChar   (tel_sendChar),
    .tel_charSent   (tel_charSent),
    .bill_sel       (bill_sel),
    .bill_out       (bill_out)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tel_startCall)  n_start++;
    if (tel_answerCall) n_ans++;
    if (tel_endCall)    n_end++;
    if (tel_sendChar) begin
      n_send++;
      if (exp_q.size() > 0)
        chk("char", tel_charSent, exp_q.pop_front());
      else
        chk("send_unexp", tel_sendChar, 0);
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return tel_startCall;
      1:       return tel_answerCall;
      2:       return tel_endCall;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_evt(
    input  string tag,
    input  int    w,
    output int    n
  );
    n = 0;
    while (!sig(w) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, sig(w), 1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    call_req = '0;
    hangup = '0;
    char_valid = '0;
    char_data = '0;
    callee_answer = 1'b0;
    callee_end = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_bill[i] = 0;
    tick();
  endtask

  task automatic pulse_answer;
    callee_answer = 1'b1;
    tick();
    callee_answer = 1'b0;
  endtask

  task automatic pulse_hangup(input int u);
    hangup[2'(u)] = 1'b1;
    tick();
    hangup[2'(u)] = 1'b0;
  endtask

  task automatic send_char(
    input int         u,
    input logic [7:0] c
  );
    int n;
    n = 0;
    char_valid[2'(u)] = 1'b1;
    char_data[{2'(u), 3'b000} +: 8] = c;
    #1;
    while (!char_ready[2'(u)] && n < 20) begin
      tick();
      n++;
    end
    chk("rdy_wait", char_ready[2'(u)], 1);
    if (c >= 8'h20 && c <= 8'h7E) begin
      exp_q.push_back(c);
      exp_bill[u] += CPC;
    end
    tick();
    chk("rdy_after", char_ready[2'(u)], 0);
    char_valid[2'(u)] = 1'b0;
  endtask

  task automatic chk_bill(input string tag, input int u);
    bill_sel = 2'(u);
    #1;
    chk(tag, bill_out, exp_bill[u]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, a0, e0, d0, bad;
    logic [3:0] order [4];
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b1000;
    order[3] = 4'b0001;

    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", char_ready, 0);
    chk("rst_tel", {tel_startCall, tel_answerCall,
                    tel_endCall, tel_sendChar,
                    tel_charSent}, 0);
    chk("rst_bill", bill_out, 0);

    // single call
    s0 = n_start; a0 = n_ans; e0 = n_end; d0 = n_send;
    call_req[0] = 1'b1;
    wait_evt("start1", 0, n);
    chk("grant1", grant, 4'b0001);
    chk("busy1", busy, 1);
    repeat (3) tick();
    pulse_answer();
    wait_evt("ans1", 1, n);
    send_char(0, 8'h57);
    tick();
    send_char(0, 8'h68);
    pulse_hangup(0);
    wait_evt("end1", 2, n);
    call_req[0] = 1'b0;
    wait_evt("idle1", 3, n);
    chk("start_cnt1", n_start - s0, 1);
    chk("ans_cnt1", n_ans - a0, 1);
    chk("end_cnt1", n_end - e0, 1);
    chk("send_cnt1", n_send - d0, 2);
    chk_bill("bill0_4", 0);
    chk("bill0_lit", bill_out, 4);

    // invalid / blocked characters
    d0 = n_send;
    call_req[0] = 1'b1;
    wait_evt("start2", 0, n);
    chk("grant2", grant, 4'b0001);
    tick();
    pulse_answer();
    wait_evt("ans2", 1, n);
    send_char(0, 8'd135);
    send_char(0, 8'd8);
    send_char(0, 8'h3F);
    pulse_hangup(0);
    wait_evt("end2", 2, n);
    call_req[0] = 1'b0;
    wait_evt("idle2", 3, n);
    chk("send_cnt2", n_send - d0, 1);
    chk_bill("bill0_6", 0);

    // ring timeout, user 2
    a0 = n_ans;
    call_req[2] = 1'b1;
    wait_evt("start3", 0, n);
    chk("grant3", grant, 4'b0100);
    wait_evt("end3", 2, n);
    chk("ring_to", n, RT + 1);
    call_req[2] = 1'b0;
    wait_evt("idle3", 3, n);
    chk("cooldown", n, CD + 1);
    chk("ans_cnt3", n_ans - a0, 0);
    chk_bill("bill2_0", 2);

    // answer coincides with timeout, then hangup vs char
    call_req[1] = 1'b1;
    wait_evt("start4", 0, n);
    chk("grant4", grant, 4'b0010);
    repeat (RT) tick();
    callee_answer = 1'b1;
    tick();
    callee_answer = 1'b0;
    chk("ans_wins", tel_answerCall, 1);
    chk("no_end4", tel_endCall, 0);
    d0 = n_send; e0 = n_end;
    hangup[1] = 1'b1;
    char_valid[1] = 1'b1;
    char_data[15:8] = 8'h41;
    #1;
    chk("rdy_hup", char_ready[1], 0);
    tick();
    hangup[1] = 1'b0;
    char_valid[1] = 1'b0;
    chk("end4", tel_endCall, 1);
    tick();
    tick();
    chk("send_cnt4", n_send - d0, 0);
    chk("end_cnt4", n_end - e0, 1);
    chk_bill("bill1_0", 1);
    call_req[1] = 1'b0;
    wait_evt("idle4", 3, n);

    // round robin 0,1,3,0
    do_reset();
    call_req = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      wait_evt("start_rr", 0, n);
      chk("rr_grant", grant, order[k]);
      tick();
      pulse_answer();
      wait_evt("ans_rr", 1, n);
      char_valid = 4'b1011;
      char_data  = {4{8'h01}};
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if ((char_ready & ~grant) != 0) bad++;
      end
      chk("rr_other_rdy", bad, 0);
      hangup = grant;
      tick();
      hangup = '0;
      char_valid = '0;
      wait_evt("end_rr", 2, n);
    end
    call_req = '0;
    wait_evt("idle_rr", 3, n);

    // reset mid-call
    do_reset();
    call_req[1] = 1'b1;
    wait_evt("start6", 0, n);
    chk("grant6", grant, 4'b0010);
    tick();
    pulse_answer();
    wait_evt("ans6", 1, n);
    for (int i = 0; i < 5; i++) send_char(1, 8'h41 + 8'(i));
    tick();
    chk_bill("bill1_10", 1);
    e0 = n_end;
    rst = 1'b1;
    for (int i = 0; i < N; i++) exp_bill[i] = 0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdy", char_ready, 0);
    chk("arst_tel", {tel_startCall, tel_answerCall,
                     tel_endCall, tel_sendChar,
                     tel_charSent}, 0);
    chk("arst_bill", bill_out, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("arst_no_end", n_end - e0, 0);
    wait_evt("start7", 0, n);
    chk("grant7", grant, 4'b0010);
    chk_bill("bill1_rst", 1);
    call_req[1] = 1'b0;
    wait_evt("end7", 2, n);
    wait_evt("idle7", 3, n);

    chk("q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
